dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Sequencing controller and two-port arbiter in front of a single-port, synchronous-read data memory.
- Requesters:
  - Core: the MEM stage, with byte, half and word loads/stores.
  - Loader/DMA: word-only, used for preload and debug access.
- Implements sub-word stores as read-modify-write.
- Implements load sign/zero extension.
- Uses byte addressing; the memory itself is word-organised.

Parameters:
- AW, 10, memory word-address width (depth 2^AW words).
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed core priority.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- core_req  in  1  core request; held with its fields stable until core_gnt.
- core_we  in  1  1 = store, 0 = load.
- core_funct3  in  3  RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- core_addr  in  32  byte address.
- core_wdata  in  32  store data, right-aligned.
- core_gnt  out  1  one-cycle pulse: request accepted.
- core_rvalid  out  1  one-cycle pulse: core_rdata valid.
- core_rdata  out  32  extended load result.
- core_err  out  1  one-cycle pulse with core_gnt: misaligned access, which is dropped.
- dma_req  in  1  DMA request; held until dma_gnt.
- dma_we  in  1  1 = word write.
- dma_addr  in  32  byte address; bits [1:0] ignored.
- dma_wdata  in  32  write data.
- dma_gnt  out  1  accept pulse.
- dma_rvalid  out  1  read-data pulse.
- dma_rdata  out  32  read word.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  word address, taken from addr[AW+1:2].
- mem_wdata  out  32  full write word.
- mem_rdata  in  32  read data; valid the cycle after mem_en && !mem_we.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0, including core_rdata and dma_rdata.
  - last_grant = DMA, so the core wins the first tie.
  - Reset mid-operation aborts with no memory write; a pending RMW write is discarded.
- States:
  - IDLE: arbitrate, latch the winner's fields, pulse its gnt.
  - RD_WAIT: capture mem_rdata, extend it, pulse rvalid. Return to IDLE.
  - RMW_RD: mem_rdata arrives; merge the store lane(s).
  - RMW_WR: mem_en = mem_we = 1 with the merged word. Return to IDLE.
- Arbitration, in IDLE only:
  - One requester active: that requester wins.
  - Both active, RR_EN = 1: the winner is the one not granted last.
  - Both active, RR_EN = 0: the core wins.
  - No grant issued while busy; requests simply wait.
- Transitions from IDLE on grant:
  - Load → issue read, go to RD_WAIT. Load latency is gnt to rvalid = 1 cycle.
  - SW or DMA write → issue write in the grant cycle, stay in IDLE. No rvalid.
  - SB/SH → issue read, go to RMW_RD, then RMW_WR. Occupancy is 3 cycles.
- Back-to-back grants are possible on consecutive cycles only after word writes.
- Alignment, core only:
  - LH/LHU/SH require addr[0] = 0.
  - LW/SW require addr[1:0] = 0.
  - A violation pulses core_gnt and core_err together, with no memory access and no rvalid.
- Undefined funct3 values (011, 110, 111): treated as misaligned, so core_err is pulsed.
- Lane select:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Loads: LB/LH sign-extend; LBU/LHU zero-extend.
- RMW lane merging replaces only the selected lane(s).
- Address wrap: addresses beyond 2^AW words alias by truncation to mem_addr.
- Read data outputs:
  - core_rdata and dma_rdata hold their last value until the next rvalid for the same requester.
  - rdata is only driven on the requester's own rvalid.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum.
  - Requester-ID constants.
- Sub-module dmem_lane_unit, combinational:
  - Store merge: old word, wdata, funct3, addr[1:0] → merged word.
  - Load extract/extend: word, funct3, addr[1:0] → result.
  - Reused by both paths.

Test Plan:
1. Reset, then DMA write addr 0x10, data 0xDEADBEEF. Core LW 0x10 → core_rvalid 1 cycle after gnt, core_rdata = 0xDEADBEEF.
2. Core SB addr 0x11, data 0x55, over 0xDEADBEEF. Then LW 0x10 → 0xDEAD55EF. Busy is high for 2 cycles after gnt.
3. Word 0x000080F0 at 0x20:
   - LB 0x20 → 0xFFFFFFF0.
   - LBU 0x20 → 0x000000F0.
   - LH 0x20 → 0xFFFF80F0.
   - LHU 0x22 → 0x00000000.
4. core_req and dma_req asserted together and held for 4 consecutive transactions, RR_EN = 1. Grants alternate core, DMA, core, DMA. With RR_EN = 0, all core grants until core_req drops.
5. Core LW at 0x13 → core_gnt and core_err in the same cycle, mem_en = 0, no rvalid. Memory contents are unchanged.
6. Assert rst in the RMW_RD cycle of an SH to 0x30 → no mem_we ever asserted. Word at 0x30 is unchanged, and all outputs are 0 the cycle after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: RV32I width codes,
// FSM states, requester identifiers and the core alignment rule.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RMW_RD,
    S_RMW_WR
  } state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  // Unsigned widths have no store form, so a store coded that way is rejected too.
  function automatic logic misaligned(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    case (f3)
      F3_B:    misaligned = 1'b0;
      F3_H:    misaligned = a[0];
      F3_W:    misaligned = |a;
      F3_BU:   misaligned = we;
      F3_HU:   misaligned = we | a[0];
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte/half lane handling shared by the load and read-modify-write paths:
// merges store data into an old word and extracts/extends load results.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign bsh    = {lane, 3'b000};
  assign hsh    = {lane[1], 4'b0000};
  assign byte_w = 8'(word >> bsh);
  assign half_w = 16'(word >> hsh);

  always_comb begin
    merged = wdata;
    case (funct3[1:0])
      2'b00:   merged = (word & ~(32'h0000_00FF << bsh)) | ({24'h0, wdata[7:0]} << bsh);
      2'b01:   merged = (word & ~(32'h0000_FFFF << hsh)) | ({16'h0, wdata[15:0]} << hsh);
      default: merged = wdata;
    endcase
  end

  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_w[7]}}, byte_w};
      F3_BU:   load_data = {24'h0, byte_w};
      F3_H:    load_data = {{16{half_w[15]}}, half_w};
      F3_HU:   load_data = {16'h0, half_w};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Arbiter and access sequencer between the core MEM stage, the loader/DMA
// port and a single-port synchronous-read data memory.
//
// state     | meaning
// S_IDLE    | arbitrate, grant, issue read or word write
// S_RD_WAIT | read data back, extend, pulse rvalid
// S_RMW_RD  | old word back, merge store lane(s)
// S_RMW_WR  | write merged word
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned AW    = 10,
  parameter bit          RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [2:0]    core_funct3,
  input  logic [31:0]   core_addr,
  input  logic [31:0]   core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [31:0]   core_rdata,
  output logic          core_err,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [31:0]   dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [31:0]   dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   merged_q, merged_d;
  logic [31:0]   core_rdata_q, core_rdata_d;
  logic [31:0]   dma_rdata_q, dma_rdata_d;

  logic [31:0]   merged_w;
  logic [31:0]   load_w;
  logic          core_win;
  logic          core_bad;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{core_addr[31:AW+2], dma_addr[31:AW+2], dma_addr[1:0]};

  assign core_win = core_req && (!dma_req || !RR_EN || (last_q == REQ_DMA));
  assign core_bad = misaligned(core_we, core_funct3, core_addr[1:0]);

  dmem_lane_unit u_lane (
    .word      (mem_rdata),
    .wdata     (wdata_q),
    .funct3    (f3_q),
    .lane      (lane_q),
    .merged    (merged_w),
    .load_data (load_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= REQ_DMA;
      id_q         <= REQ_CORE;
      f3_q         <= F3_W;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      waddr_q      <= '0;
      merged_q     <= '0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      waddr_q      <= waddr_d;
      merged_q     <= merged_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    f3_d         = f3_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    waddr_d      = waddr_q;
    merged_d     = merged_q;
    core_rdata_d = core_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    core_gnt     = 1'b0;
    core_err     = 1'b0;
    core_rvalid  = 1'b0;
    dma_gnt      = 1'b0;
    dma_rvalid   = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        if (core_win) begin
          core_gnt = 1'b1;
          last_d   = REQ_CORE;
          if (core_bad) begin
            core_err = 1'b1;
          end else begin
            mem_en   = 1'b1;
            mem_addr = core_addr[AW+1:2];
            id_d     = REQ_CORE;
            f3_d     = core_funct3;
            lane_d   = core_addr[1:0];
            wdata_d  = core_wdata;
            waddr_d  = core_addr[AW+1:2];
            if (!core_we) begin
              state_d = S_RD_WAIT;
            end else if (core_funct3 == F3_W) begin
              mem_we    = 1'b1;
              mem_wdata = core_wdata;
            end else begin
              state_d = S_RMW_RD;
            end
          end
        end else if (dma_req) begin
          dma_gnt  = 1'b1;
          last_d   = REQ_DMA;
          mem_en   = 1'b1;
          mem_addr = dma_addr[AW+1:2];
          id_d     = REQ_DMA;
          f3_d     = F3_W;
          lane_d   = 2'b00;
          if (dma_we) begin
            mem_we    = 1'b1;
            mem_wdata = dma_wdata;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (id_q == REQ_CORE) begin
          core_rvalid  = 1'b1;
          core_rdata_d = load_w;
        end else begin
          dma_rvalid  = 1'b1;
          dma_rdata_d = load_w;
        end
        state_d = S_IDLE;
      end
      S_RMW_RD: begin
        merged_d = merged_w;
        state_d  = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = waddr_q;
        mem_wdata = merged_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    core_rdata = core_rdata_d;
    dma_rdata  = dma_rdata_d;
    busy       = (state_q != S_IDLE);

    // Quiet every output while reset is held so an aborted RMW never writes.
    if (rst) begin
      core_gnt    = 1'b0;
      core_err    = 1'b0;
      core_rvalid = 1'b0;
      core_rdata  = '0;
      dma_gnt     = 1'b0;
      dma_rvalid  = 1'b0;
      dma_rdata   = '0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      busy        = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, arbitration and
// reset-abort sequences, then random traffic against a byte-array model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          core_req = 1'b0, core_we = 1'b0;
  logic [2:0]    core_funct3 = 3'b0;
  logic [31:0]   core_addr = '0, core_wdata = '0;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0]   dma_addr = '0, dma_wdata = '0;
  logic          core_gnt, core_rvalid, core_err, dma_gnt, dma_rvalid;
  logic [31:0]   core_rdata, dma_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic          fp_core_gnt, fp_core_rvalid, fp_core_err, fp_dma_gnt, fp_dma_rvalid;
  logic [31:0]   fp_core_rdata, fp_dma_rdata;
  logic          fp_mem_en, fp_mem_we, fp_busy;
  logic [AW-1:0] fp_mem_addr;
  logic [31:0]   fp_mem_wdata;
  logic [31:0]   fp_mem_rdata = '0;

  dmem_ctrl #(.AW(AW), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .core_err(core_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_ctrl #(.AW(AW), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(fp_core_gnt), .core_rvalid(fp_core_rvalid), .core_rdata(fp_core_rdata),
    .core_err(fp_core_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(fp_dma_gnt), .dma_rvalid(fp_dma_rvalid), .dma_rdata(fp_dma_rdata),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_rdata(fp_mem_rdata), .busy(fp_busy)
  );

  // Synchronous-read memory attached to the round-robin instance.
  logic [31:0] mem_arr [1<<AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_core = '0;
  logic [31:0] last_dma  = '0;
  bit          mon_en = 1'b0;
  int          we_cnt = 0;

  always @(negedge clk) if (mon_en && mem_we) we_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-addressed reference memory (little-endian), aliased at 2^(AW+2) bytes.
  logic [7:0] ref_b [1<<(AW+2)];

  function automatic bit ref_bad(bit we, logic [2:0] f3, logic [31:0] a);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      3'b100:  return we;
      3'b101:  return we || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    int n, base;
    longint v;
    n = 1 << f3[1:0];
    base = int'(a[AW+1:0]);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_b[base + i]) << (8 * i));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n, base;
    logic [31:0] t;
    n = 1 << f3[1:0];
    base = int'(a[AW+1:0]);
    for (int i = 0; i < n; i++) begin
      t = d >> (8 * i);
      ref_b[base + i] = t[7:0];
    end
  endtask

  // Drive one request, wait for its grant, then check the response protocol.
  task automatic do_op(input bit src, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic got_err, output logic [31:0] got_rd);
    bit seen;
    seen = 1'b0;
    got_err = 1'b0;
    got_rd = '0;
    if (src) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wdata;
    end
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (src ? dma_gnt : core_gnt) begin
        seen = 1'b1;
        got_err = core_err;
        if (core_err) chk("err_no_mem_en", {31'b0, mem_en}, 32'd0);
      end
      @(posedge clk); #1;
    end
    core_req = 1'b0;
    dma_req = 1'b0;
    chk("gnt_seen", {31'b0, seen}, 32'd1);
    if (!seen) return;
    @(negedge clk);
    if (!we && !got_err) begin
      chk("rvalid_lat", {31'b0, src ? dma_rvalid : core_rvalid}, 32'd1);
      got_rd = src ? dma_rdata : core_rdata;
    end else begin
      chk("no_rvalid", {31'b0, core_rvalid | dma_rvalid}, 32'd0);
      if (!src && we && !got_err && f3 != F3_W) begin
        chk("busy_rmw1", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_rmw2", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_done", {31'b0, busy}, 32'd0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input bit src, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic got_err, output logic [31:0] got_rd,
                        output bit exp_err, output logic [31:0] exp_rd);
    logic [2:0]  mf3;
    logic [31:0] ma;
    mf3 = src ? F3_W : f3;
    ma = src ? (addr & ~32'h3) : addr;
    exp_err = src ? 1'b0 : ref_bad(we, mf3, ma);
    exp_rd = (!exp_err && !we) ? ref_load(mf3, ma) : 32'h0;
    do_op(src, we, f3, addr, wdata, got_err, got_rd);
    if (!exp_err) begin
      if (we) ref_store(mf3, ma, wdata);
      else if (src) last_dma = exp_rd;
      else last_core = exp_rd;
    end
    chk("core_rdata_hold", core_rdata, last_core);
    chk("dma_rdata_hold", dma_rdata, last_dma);
  endtask

  typedef struct {
    string       name;
    bit          src;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(string name, bit src, bit we, logic [2:0] f3,
                              logic [31:0] addr, logic [31:0] wdata,
                              bit exp_err, bit chk_rd, logic [31:0] exp_rd);
    vec_t v;
    v.name = name; v.src = src; v.we = we; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.exp_err = exp_err; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check_all_zero(input string name);
    chk({name, "_ctl"}, {24'b0, core_gnt, core_rvalid, core_err, dma_gnt,
                         dma_rvalid, mem_en, mem_we, busy}, 32'd0);
    chk({name, "_core_rdata"}, core_rdata, 32'd0);
    chk({name, "_dma_rdata"}, dma_rdata, 32'd0);
    chk({name, "_mem_addr"}, {22'b0, mem_addr}, 32'd0);
    chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic        g_err;
    logic [31:0] g_rd, e_rd;
    bit          e_err;

    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = '0;
    for (int i = 0; i < (1 << (AW + 2)); i++) ref_b[i] = '0;

    tbl.push_back(mk("dma_wr10",  1, 1, F3_W,   32'h10,   32'hDEADBEEF, 0, 0, 32'h0));
    tbl.push_back(mk("lw10",      0, 0, F3_W,   32'h10,   32'h0,        0, 1, 32'hDEADBEEF));
    tbl.push_back(mk("sb11",      0, 1, F3_B,   32'h11,   32'hFFFFFF55, 0, 0, 32'h0));
    tbl.push_back(mk("lw10_sb",   0, 0, F3_W,   32'h10,   32'h0,        0, 1, 32'hDEAD55EF));
    tbl.push_back(mk("dma_wr20",  1, 1, F3_W,   32'h20,   32'h000080F0, 0, 0, 32'h0));
    tbl.push_back(mk("lb20",      0, 0, F3_B,   32'h20,   32'h0,        0, 1, 32'hFFFFFFF0));
    tbl.push_back(mk("lbu20",     0, 0, F3_BU,  32'h20,   32'h0,        0, 1, 32'h000000F0));
    tbl.push_back(mk("lh20",      0, 0, F3_H,   32'h20,   32'h0,        0, 1, 32'hFFFF80F0));
    tbl.push_back(mk("lhu22",     0, 0, F3_HU,  32'h22,   32'h0,        0, 1, 32'h00000000));
    tbl.push_back(mk("lbu21",     0, 0, F3_BU,  32'h21,   32'h0,        0, 1, 32'h00000080));
    tbl.push_back(mk("lb21",      0, 0, F3_B,   32'h21,   32'h0,        0, 1, 32'hFFFFFF80));
    tbl.push_back(mk("lw13_mis",  0, 0, F3_W,   32'h13,   32'h0,        1, 0, 32'h0));
    tbl.push_back(mk("sw12_mis",  0, 1, F3_W,   32'h12,   32'h0BADF00D, 1, 0, 32'h0));
    tbl.push_back(mk("sh11_mis",  0, 1, F3_H,   32'h11,   32'h00000BAD, 1, 0, 32'h0));
    tbl.push_back(mk("lh21_mis",  0, 0, F3_H,   32'h21,   32'h0,        1, 0, 32'h0));
    tbl.push_back(mk("f3_011",    0, 0, 3'b011, 32'h10,   32'h0,        1, 0, 32'h0));
    tbl.push_back(mk("f3_110",    0, 0, 3'b110, 32'h10,   32'h0,        1, 0, 32'h0));
    tbl.push_back(mk("lw10_keep", 0, 0, F3_W,   32'h10,   32'h0,        0, 1, 32'hDEAD55EF));
    tbl.push_back(mk("sh12",      0, 1, F3_H,   32'h12,   32'hABCD1234, 0, 0, 32'h0));
    tbl.push_back(mk("lw10_sh",   0, 0, F3_W,   32'h10,   32'h0,        0, 1, 32'h123455EF));
    tbl.push_back(mk("lb13",      0, 0, F3_B,   32'h13,   32'h0,        0, 1, 32'h00000012));
    tbl.push_back(mk("dma_rd23",  1, 0, F3_W,   32'h23,   32'h0,        0, 1, 32'h000080F0));
    tbl.push_back(mk("sw_alias",  0, 1, F3_W,   32'h1034, 32'h5A5A5A5A, 0, 0, 32'h0));
    tbl.push_back(mk("lw34",      0, 0, F3_W,   32'h34,   32'h0,        0, 1, 32'h5A5A5A5A));
    tbl.push_back(mk("sb37",      0, 1, F3_B,   32'h37,   32'h000000A5, 0, 0, 32'h0));
    tbl.push_back(mk("lw34_sb",   0, 0, F3_W,   32'h34,   32'h0,        0, 1, 32'hA55A5A5A));

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // Directed vectors
    foreach (tbl[i]) begin
      run_op(tbl[i].src, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
             g_err, g_rd, e_err, e_rd);
      chk({tbl[i].name, "_err"}, {31'b0, g_err}, {31'b0, tbl[i].exp_err});
      if (tbl[i].chk_rd) chk({tbl[i].name, "_rd"}, g_rd, tbl[i].exp_rd);
    end

    // Arbitration with both requesters held: reset so the core wins the first tie
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_core = '0;
    last_dma = '0;
    core_req = 1'b1; core_we = 1'b1; core_funct3 = F3_W; core_addr = 32'h40; core_wdata = 32'h11112222;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h44; dma_wdata = 32'h33334444;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_core_gnt", {31'b0, core_gnt}, {31'b0, i % 2 == 0});
      chk("rr_dma_gnt", {31'b0, dma_gnt}, {31'b0, i % 2 == 1});
      chk("fp_core_gnt", {31'b0, fp_core_gnt}, 32'd1);
      chk("fp_dma_gnt", {31'b0, fp_dma_gnt}, 32'd0);
      @(posedge clk); #1;
    end
    core_req = 1'b0;
    @(negedge clk);
    chk("rr_dma_alone", {31'b0, dma_gnt}, 32'd1);
    chk("fp_dma_alone", {31'b0, fp_dma_gnt}, 32'd1);
    @(posedge clk); #1;
    dma_req = 1'b0;
    ref_store(F3_W, 32'h40, 32'h11112222);
    ref_store(F3_W, 32'h44, 32'h33334444);
    run_op(0, 0, F3_W, 32'h40, 32'h0, g_err, g_rd, e_err, e_rd);
    chk("arb_core_word", g_rd, 32'h11112222);
    run_op(1, 0, F3_W, 32'h44, 32'h0, g_err, g_rd, e_err, e_rd);
    chk("arb_dma_word", g_rd, 32'h33334444);

    // Random single-requester traffic against the byte model
    for (int k = 0; k < 300; k++) begin
      bit          src, we;
      logic [2:0]  f3;
      logic [31:0] a;
      src = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      run_op(src, we, f3, a, $urandom, g_err, g_rd, e_err, e_rd);
      chk("rnd_err", {31'b0, g_err}, {31'b0, e_err});
      if (!e_err && !we) chk("rnd_rd", g_rd, e_rd);
    end

    // Reset during the RMW_RD cycle of an SH must discard the write
    run_op(1, 1, F3_W, 32'h30, 32'hCAFEF00D, g_err, g_rd, e_err, e_rd);
    we_cnt = 0;
    mon_en = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_funct3 = F3_H; core_addr = 32'h30; core_wdata = 32'h0000BEEF;
    @(negedge clk);
    chk("abort_gnt", {31'b0, core_gnt}, 32'd1);
    @(posedge clk); #1;
    core_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy_rmw", {31'b0, busy | mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_core = '0;
    last_dma = '0;
    @(negedge clk);
    check_all_zero("post_abort");
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("abort_no_we", 32'(we_cnt), 32'd0);
    @(posedge clk); #1;
    run_op(0, 0, F3_W, 32'h30, 32'h0, g_err, g_rd, e_err, e_rd);
    chk("abort_word_kept", g_rd, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
